// File: rtl/pulse_wave.sv
// Programmable pulse/square/one-shot waveform generator with period-boundary
// double-buffered controls and a registered period-start strobe.
module pulse_wave #(
  parameter int unsigned resolution_bits = 8,
  parameter int unsigned counter_width   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [counter_width-1:0]   frequency_control,
  input  logic [counter_width-1:0]   duty_control,
  input  logic [resolution_bits-1:0] amplitude,
  input  logic [1:0]                 mode,
  output logic [resolution_bits-1:0] wave_out,
  output logic                       period_start,
  output logic                       active
);

  localparam int unsigned CW = counter_width;
  localparam int unsigned RW = resolution_bits;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] p_s, p_s_n;
  logic [CW-1:0] h_s, h_s_n;
  logic [RW-1:0] a_s, a_s_n;
  logic [1:0]    m_s, m_s_n;
  logic [RW-1:0] wave_n;
  logic          ps_n;
  logic          active_n;

  logic          start_c;
  logic          load_c;
  logic [CW-1:0] heff_in_c;
  logic [CW-1:0] heff_s_c;
  logic [CW-1:0] cnt_inc_c;

  // High-phase length: half period for square, else duty clipped to period.
  function automatic logic [CW-1:0] heff(input logic [1:0]    m,
                                         input logic [CW-1:0] p,
                                         input logic [CW-1:0] h);
    if (m == 2'd0) return p >> 1;
    return (h < p) ? h : p;
  endfunction

  assign start_c   = enable && (frequency_control >= CW'(2));
  assign heff_in_c = heff(mode, frequency_control, duty_control);
  assign heff_s_c  = heff(m_s, p_s, h_s);
  assign cnt_inc_c = cnt + CW'(1);

  // Next-state and next-output logic.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    p_s_n    = p_s;
    h_s_n    = h_s;
    a_s_n    = a_s;
    m_s_n    = m_s;
    wave_n   = '0;
    ps_n     = 1'b0;
    active_n = 1'b0;
    load_c   = 1'b0;

    case (state)
      IDLE: begin
        if (start_c) load_c = 1'b1;
      end
      RUN: begin
        if (cnt < p_s - CW'(1)) begin
          cnt_n    = cnt_inc_c;
          wave_n   = (cnt_inc_c < heff_s_c) ? a_s : '0;
          active_n = 1'b1;
        end else if (m_s == 2'd2) begin
          state_n = DONE;
        end else if (start_c) begin
          load_c = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      DONE: begin
        if (!enable) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Load edge: sample controls and emit the first sample of a new period.
    if (load_c) begin
      p_s_n    = frequency_control;
      h_s_n    = duty_control;
      a_s_n    = amplitude;
      m_s_n    = mode;
      cnt_n    = '0;
      ps_n     = 1'b1;
      active_n = 1'b1;
      state_n  = RUN;
      wave_n   = (heff_in_c != '0) ? amplitude : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      p_s          <= '0;
      h_s          <= '0;
      a_s          <= '0;
      m_s          <= '0;
      wave_out     <= '0;
      period_start <= 1'b0;
      active       <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      p_s          <= p_s_n;
      h_s          <= h_s_n;
      a_s          <= a_s_n;
      m_s          <= m_s_n;
      wave_out     <= wave_n;
      period_start <= ps_n;
      active       <= active_n;
    end
  end

endmodule

// File: tb/tb_pulse_wave.sv
// Directed scoreboard bench for pulse_wave: stimulus queues expected outputs,
// a monitor pops and compares one entry per clock edge.
module tb_pulse_wave;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] frequency_control;
  logic [15:0] duty_control;
  logic [7:0]  amplitude;
  logic [1:0]  mode;
  logic [7:0]  wave_out;
  logic        period_start;
  logic        active;

  typedef struct packed {
    logic [7:0] w;
    logic       ps;
    logic       act;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc_no = 0;

  pulse_wave #(.resolution_bits(8), .counter_width(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .frequency_control(frequency_control),
    .duty_control     (duty_control),
    .amplitude        (amplitude),
    .mode             (mode),
    .wave_out         (wave_out),
    .period_start     (period_start),
    .active           (active)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc_no, got, exp);
    end
  endtask

  // Monitor: one expected entry per edge, sampled 1 time unit after it.
  always @(posedge clk) begin
    #1;
    cyc_no++;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      check("wave_out", wave_out, mon_e.w);
      check("period_start", {7'd0, period_start}, {7'd0, mon_e.ps});
      check("active", {7'd0, active}, {7'd0, mon_e.act});
    end
  end

  // Queue the expected result of the next edge, then wait past it.
  task automatic cyc(input logic [7:0] w, input logic ps, input logic act);
    exp_t e;
    e.w = w; e.ps = ps; e.act = act;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic seg(input int n, input logic [7:0] w);
    for (int i = 0; i < n; i++) cyc(w, 1'b0, 1'b1);
  endtask

  // Full period: hi cycles at level a, then lo cycles at 0, strobe on first.
  task automatic period(input int hi, input int lo, input logic [7:0] a);
    for (int i = 0; i < hi + lo; i++)
      cyc((i < hi) ? a : 8'h00, (i == 0), 1'b1);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; frequency_control = '0;
    duty_control = '0; amplitude = '0; mode = 2'd0;
    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b0);

    // Square, P=20: 10 high / 10 low, back-to-back periods.
    reset = 1'b0; enable = 1'b1; frequency_control = 16'd20;
    mode = 2'd0; amplitude = 8'hFF;
    period(10, 10, 8'hFF);
    period(10, 10, 8'hFF);

    // Pulse, P=10 H=3, then H=0 keeps the period running at 0.
    frequency_control = 16'd10; duty_control = 16'd3;
    mode = 2'd1; amplitude = 8'h40;
    period(3, 7, 8'h40);
    period(3, 7, 8'h40);
    duty_control = 16'd0;
    period(0, 10, 8'h40);

    // Mid-period change 20 -> 6 takes effect only at the period end.
    frequency_control = 16'd20; mode = 2'd0; amplitude = 8'hFF;
    cyc(8'hFF, 1'b1, 1'b1);
    seg(4, 8'hFF);
    frequency_control = 16'd6;
    seg(5, 8'hFF);
    seg(10, 8'h00);
    period(3, 3, 8'hFF);
    period(3, 3, 8'hFF);

    // Invalid period mid-period: finish, then IDLE; P=5 restarts.
    cyc(8'hFF, 1'b1, 1'b1);
    seg(1, 8'hFF);
    frequency_control = 16'd1;
    seg(1, 8'hFF);
    frequency_control = 16'd0;
    seg(3, 8'h00);
    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b0);
    frequency_control = 16'd5;
    period(2, 3, 8'hFF);

    // One-shot, P=8 H=12: 8 cycles high, then DONE until enable falls.
    mode = 2'd2; frequency_control = 16'd8; duty_control = 16'd12;
    amplitude = 8'h80;
    period(8, 0, 8'h80);
    repeat (4) cyc(8'h00, 1'b0, 1'b0);
    enable = 1'b0;
    cyc(8'h00, 1'b0, 1'b0);
    enable = 1'b1;
    period(8, 0, 8'h80);
    cyc(8'h00, 1'b0, 1'b0);
    enable = 1'b0;
    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b0);

    // Reset during the high phase, then restart on the first edge after release.
    enable = 1'b1; frequency_control = 16'd20; mode = 2'd0; amplitude = 8'hFF;
    cyc(8'hFF, 1'b1, 1'b1);
    seg(3, 8'hFF);
    reset = 1'b1;
    cyc(8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    period(10, 10, 8'hFF);
    enable = 1'b0;
    cyc(8'h00, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain left=%0d expected=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
